unbitreverse: RTL and testbench
===============================

UNBITREVERSE -- requirements
Module: unbitreverse

Interface
REQ-001 Parameter LGSIZE, default 5, log2 of the FFT block size N=2^LGSIZE; N/2 input steps per block; the legal range is 3..12.
REQ-002 Parameter WIDTH, default 24, width of each real/imag component; a sample is 2*WIDTH bits.
REQ-003 i_clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 i_reset_n  input  1  reset; synchronous, active-low.
REQ-005 i_ce  input  1  step enable; one input pair is consumed and one output pair is produced per cycle with i_ce=1.
REQ-006 i_sync  input  1  marks input step 0 of a block; sampled only when i_ce=1.
REQ-007 i_in_0, i_in_1  input  2*WIDTH each  input pair, in bit-reversed order.
REQ-008 o_out_0, o_out_1  output  2*WIDTH each  output pair, registered, in natural order.
REQ-009 o_sync  output  1  registered; high with output step 0 of each valid block.
REQ-010 o_err  output  1  registered; one-cycle pulse on a misplaced i_sync.

Function
REQ-011 Input order: at input step k (0..N/2-1), i_in_0=X[rev(2k)] and i_in_1=X[rev(2k+1)], where rev() is the LGSIZE-bit bit reversal.
REQ-012 Output order: at output step k, o_out_0=X[2k] and o_out_1=X[2k+1].
REQ-013 Buffering: a ping-pong memory of 2 halves x N samples; one block is written while the other is read; two samples are written and two read per step.
REQ-014 Step counter: LGSIZE-1 bits; it increments on each i_ce=1 cycle outside WAIT_SYNC and wraps N/2-1 -> 0; the buffer half toggles on wrap.
REQ-015 State WAIT_SYNC: input is discarded; outputs are 0; on i_ce&i_sync the pair is written as step 0, the counter becomes 1, and the state moves to FILL.
REQ-016 State FILL: the first block is written; outputs are 0 and o_sync=0; when step N/2-1 is accepted, the state moves to RUN.
REQ-017 State RUN: on each i_ce cycle, output step k of the previous block is presented and input step k of the current block is written.
REQ-018 Latency: output step k of block B is valid in the cycle after the i_ce edge that accepts input step k of block B+1, which is exactly N/2 accepted steps later.
REQ-019 When i_ce=0, the counter, state, memory, o_out_*, and o_sync hold; o_err returns to 0.
REQ-020 o_sync=1 exactly for output step 0 in RUN; it is 0 in FILL and in WAIT_SYNC.
REQ-021 i_sync=1 in RUN or FILL with counter=0 is the expected alignment; no action is taken.
REQ-022 i_sync absent at counter=0 in RUN is tolerated; the block continues free-running.
REQ-023 Misplaced sync (i_ce&i_sync with counter!=0):
  - o_err pulses for 1 cycle;
  - the pair is written as step 0 of a new block and the counter becomes 1;
  - the state moves to FILL and outputs are forced to 0;
  - the partially written block is discarded.
REQ-024 Data passes through with no arithmetic: widths are preserved, with no rounding or sign handling.
REQ-025 Read-during-write never targets the same half, so no bypass logic is required.

Reset
REQ-026 While i_reset_n=0 at a clock edge, the following take effect on the next cycle:
  - state=WAIT_SYNC, counter=0, half select=0;
  - o_out_0=0, o_out_1=0, o_sync=0, o_err=0.
REQ-027 Reset applied mid-block or mid-RUN discards all buffered data; memory contents need not be cleared.
REQ-028 i_ce and i_sync are ignored while reset is asserted.

Verification (LGSIZE=3, N=8, X[n]=n+1, both components equal)
REQ-029 Basic: continuous i_ce, i_sync on the first step, with inputs (1,5),(3,7),(2,6),(4,8), then a second identical block.
  - Required response: starting the cycle after the 5th accepted step, outputs are (1,2),(3,4),(5,6),(7,8).
  - o_sync=1 on (1,2) only.
  - Outputs are 0 during the first 4 steps.
REQ-030 No sync: 8 steps with i_sync=0 after reset -> outputs stay 0, o_sync never asserts, o_err=0.
REQ-031 Stall: i_ce toggles 1/0 every cycle using the REQ-029 data.
  - Required response: the same output sequence as REQ-029, with each value held through the i_ce=0 cycles.
REQ-032 Misplaced sync: in RUN, i_sync is asserted at step 2.
  - Required response: o_err=1 for 1 cycle, and outputs are 0 for the next 3 steps.
  - The block restarting at that step is then output in natural order, with o_sync on its first pair.
REQ-033 Continuity: 3 back-to-back blocks (X, X+8, X+16).
  - Required response: 12 consecutive natural-order output pairs (1,2)...(23,24) with no gaps.
  - o_sync asserts every 4th accepted step.
REQ-034 Mid-run reset: i_reset_n=0 for 1 cycle during RUN.
  - Required response: all outputs are 0 the next cycle, and the block stays silent until i_sync followed by a full fill of 4 steps.

Source files
------------

// File: rtl/unbitreverse_if.sv
// unbitreverse_if: step-enable, sync and sample-pair bus for the bit-reverse reorder block.
interface unbitreverse_if #(
   parameter int WIDTH = 24
);
   logic i_ce;
   logic i_sync;
   logic [2*WIDTH-1:0] i_in_0;
   logic [2*WIDTH-1:0] i_in_1;
   logic [2*WIDTH-1:0] o_out_0;
   logic [2*WIDTH-1:0] o_out_1;
   logic o_sync;
   logic o_err;
   modport master (
      output i_ce, i_sync, i_in_0, i_in_1,
      input  o_out_0, o_out_1, o_sync, o_err
   );
   modport slave (
      input  i_ce, i_sync, i_in_0, i_in_1,
      output o_out_0, o_out_1, o_sync, o_err
   );
endinterface

// File: rtl/unbitreverse.sv
// unbitreverse: reorders bit-reversed FFT sample pairs into natural order
// through a ping-pong buffer, one pair in and one pair out per enabled step.
module unbitreverse #(
   parameter int LGSIZE = 5,
   parameter int WIDTH = 24
) (
   input logic i_clk,
   input logic i_reset_n,
   unbitreverse_if.slave bus
);
   localparam int SW = 2 * WIDTH;
   localparam int CW = LGSIZE - 1;
   localparam logic [CW-1:0] LAST = '1;
   typedef enum logic [1:0] {WAIT_SYNC, FILL, RUN} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n, ws, wi0, wi1;
   logic hsel, hsel_n, sync_n, err_n, misplaced, we;
   logic [SW-1:0] out0_n, out1_n, rd0, rd1, wd0, wd1;
   logic [LGSIZE-1:0] wa;
   logic [SW-1:0] bank0 [2**LGSIZE];
   logic [SW-1:0] bank1 [2**LGSIZE];

   function automatic logic [LGSIZE-1:0] rev(input logic [LGSIZE-1:0] a);
      logic [LGSIZE-1:0] r;
      for (int i = 0; i < LGSIZE; i++) r[i] = a[LGSIZE-1-i];
      return r;
   endfunction

   // Bank = addr[0]^addr[MSB]: the two write addresses of a step (rev(2k), rev(2k)+N/2)
   // and the two read addresses (2k, 2k+1) always fall in opposite banks.
   assign misplaced = bus.i_sync && cnt != '0 && state != WAIT_SYNC;
   assign ws = misplaced ? '0 : cnt;
   assign wa = rev({ws, 1'b0});
   assign wi0 = wa[0] ? {1'b1, wa[LGSIZE-2:1]} : wa[LGSIZE-1:1];
   assign wi1 = wa[0] ? wa[LGSIZE-1:1] : {1'b1, wa[LGSIZE-2:1]};
   assign wd0 = wa[0] ? bus.i_in_1 : bus.i_in_0;
   assign wd1 = wa[0] ? bus.i_in_0 : bus.i_in_1;
   assign we = i_reset_n && bus.i_ce && (state != WAIT_SYNC || bus.i_sync);
   assign rd0 = bank0[{~hsel, cnt}];
   assign rd1 = bank1[{~hsel, cnt}];

   always_ff @(posedge i_clk)
      if (we) begin
         bank0[{hsel, wi0}] <= wd0;
         bank1[{hsel, wi1}] <= wd1;
      end

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      hsel_n = hsel;
      out0_n = bus.o_out_0;
      out1_n = bus.o_out_1;
      sync_n = bus.o_sync;
      err_n = 1'b0;
      if (bus.i_ce) begin
         out0_n = '0;
         out1_n = '0;
         sync_n = 1'b0;
         if (misplaced) begin
            err_n = 1'b1;
            cnt_n = CW'(1);
            state_n = FILL;
         end else if (state == WAIT_SYNC) begin
            cnt_n = bus.i_sync ? CW'(1) : cnt;
            state_n = bus.i_sync ? FILL : WAIT_SYNC;
         end else begin
            cnt_n = cnt + 1'b1;
            hsel_n = (cnt == LAST) ? ~hsel : hsel;
            state_n = (cnt == LAST) ? RUN : state;
            if (state == RUN) begin
               out0_n = cnt[CW-1] ? rd1 : rd0;
               out1_n = cnt[CW-1] ? rd0 : rd1;
               sync_n = cnt == '0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state <= WAIT_SYNC;
         cnt <= '0;
         hsel <= 1'b0;
         bus.o_out_0 <= '0;
         bus.o_out_1 <= '0;
         bus.o_sync <= 1'b0;
         bus.o_err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         hsel <= hsel_n;
         bus.o_out_0 <= out0_n;
         bus.o_out_1 <= out1_n;
         bus.o_sync <= sync_n;
         bus.o_err <= err_n;
      end
   end
endmodule

// File: tb/tb_unbitreverse.sv
// tb_unbitreverse: directed scoreboard bench for unbitreverse at LGSIZE=3, WIDTH=8.
module tb_unbitreverse;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   unbitreverse_if #(.WIDTH(8)) bus();
   unbitreverse #(.LGSIZE(3), .WIDTH(8)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

   typedef struct {
      int t;
      int n;
      logic [15:0] o0;
      logic [15:0] o1;
      logic s;
      logic e;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int fails = 0;
   int tid = 0;
   int nstep = 0;
   int lx0 = 0;
   int lx1 = 0;
   logic lxs = 1'b0;

   function automatic logic [15:0] smp(input int v);
      logic [7:0] b;
      b = 8'(v);
      return {b, b};
   endfunction

   task automatic cyc(input logic rn, input logic ce, input logic sy, input int a, input int b,
                      input int x0, input int x1, input logic xs, input logic xe);
      exp_t e;
      @(negedge clk);
      rst_n = rn;
      bus.i_ce = ce;
      bus.i_sync = sy;
      bus.i_in_0 = smp(a);
      bus.i_in_1 = smp(b);
      e.t = tid;
      e.n = nstep++;
      e.o0 = smp(x0);
      e.o1 = smp(x1);
      e.s = xs;
      e.e = xe;
      q.push_back(e);
      lx0 = x0;
      lx1 = x1;
      lxs = xs;
   endtask

   task automatic rst();
      cyc(1'b0, 1'b1, 1'b1, 9, 9, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic blk(input int off, input logic on, input int eoff, input logic stall);
      int ins[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, k == 0, ins[2*k] + off, ins[2*k+1] + off,
             on ? 2*k + 1 + eoff : 0, on ? 2*k + 2 + eoff : 0, on && k == 0, 1'b0);
         if (stall) cyc(1'b1, 1'b0, 1'b1, 99, 99, lx0, lx1, lxs, 1'b0);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.o_out_0 !== e.o0 || bus.o_out_1 !== e.o1 || bus.o_sync !== e.s || bus.o_err !== e.e) begin
               fails++;
               $display("FAIL t%0d step%0d: got out0=%h out1=%h sync=%b err=%b, expected %h %h %b %b",
                        e.t, e.n, bus.o_out_0, bus.o_out_1, bus.o_sync, bus.o_err, e.o0, e.o1, e.s, e.e);
            end
         end
      end
   end

   initial begin
      bus.i_ce = 1'b0;
      bus.i_sync = 1'b0;
      bus.i_in_0 = '0;
      bus.i_in_1 = '0;
      tid = 1;
      rst();
      blk(0, 1'b0, 0, 1'b0);
      blk(0, 1'b1, 0, 1'b0);
      tid = 2;
      rst();
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0, k + 1, k + 10, 0, 0, 1'b0, 1'b0);
      tid = 3;
      rst();
      blk(0, 1'b0, 0, 1'b1);
      blk(0, 1'b1, 0, 1'b1);
      tid = 4;
      rst();
      blk(0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1, 5, 1, 2, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 3, 7, 3, 4, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1, 5, 0, 0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 3, 7, 0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 2, 6, 0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 4, 8, 0, 0, 1'b0, 1'b0);
      blk(0, 1'b1, 0, 1'b0);
      tid = 5;
      rst();
      blk(0, 1'b0, 0, 1'b0);
      blk(8, 1'b1, 0, 1'b0);
      blk(16, 1'b1, 8, 1'b0);
      blk(24, 1'b1, 16, 1'b0);
      tid = 6;
      rst();
      blk(0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1, 5, 1, 2, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 3, 7, 3, 4, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 2, 6, 0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 2, 6, 0, 0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 4, 8, 0, 0, 1'b0, 1'b0);
      blk(0, 1'b0, 0, 1'b0);
      blk(0, 1'b1, 0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending entries, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
